// File: rtl/sec_ones_ctrl.sv
// Seconds-ones BCD stage of the countdown timer: tick prescaler, ones digit,
// borrow pulse to the mod6 tens digit, and the IDLE/RUN/PAUSE/DONE run control.
module sec_ones_ctrl #(
  parameter int TICK_DIV = 100
) (
  input  logic       clock,
  input  logic       clr,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       start,
  input  logic       stop,
  input  logic       tens_zero,
  output logic [3:0] ones,
  output logic       tens_en,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          zero_all;
  logic [3:0]    load_val;

  assign tick     = (state == RUN) && (presc == PMAX);
  assign zero_all = (ones == 4'd0) && tens_zero;
  assign load_val = (data > 4'd9) ? 4'd9 : data;
  // Combinational so mod6 decrements on the same edge as the 0->9 wrap;
  // gated by state, so an async clr drops it at once.
  assign tens_en  = tick && (ones == 4'd0) && !tens_zero;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      ones    <= 4'd0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (!loadn) begin
            ones    <= load_val;
            presc   <= '0;
            state   <= IDLE;
          end else if (start && !stop) begin
            if (zero_all) begin
              state <= DONE;
              presc <= '0;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (ones != 4'd0)   ones <= ones - 4'd1;
            else if (!tens_zero) ones <= 4'd9;
          end
          // Reaching 00 outranks a pause request on the same tick.
          if (tick && zero_all) begin
            state   <= DONE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        DONE: begin
          if (!loadn) begin
            ones  <= load_val;
            presc <= '0;
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sec_ones_ctrl.sv
// Directed bench for sec_ones_ctrl at TICK_DIV=4; expected values hand-derived.
module tb_sec_ones_ctrl;

  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] data = 4'd0;
  logic       loadn = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tens_zero = 1'b0;
  logic [3:0] ones;
  logic       tens_en;
  logic       running;
  logic       done;

  int nvec = 0;
  int nerr = 0;

  sec_ones_ctrl #(.TICK_DIV(4)) dut (
    .clock(clock), .clr(clr), .data(data), .loadn(loadn), .start(start),
    .stop(stop), .tens_zero(tens_zero), .ones(ones), .tens_en(tens_en),
    .running(running), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [3:0] d, input logic tz);
    data = d; tens_zero = tz; loadn = 1'b0;
    step();
    loadn = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // 1: async reset
    #2;
    chk("rst_ones", ones, 0); chk("rst_run", running, 0);
    chk("rst_done", done, 0); chk("rst_ten", tens_en, 0);
    #10 clr = 1'b0;
    step(); step();
    chk("idle_ones", ones, 0); chk("idle_run", running, 0);
    chk("idle_done", done, 0); chk("idle_ten", tens_en, 0);

    // 2: 3,2,1,0,9 with one borrow pulse
    do_load(4'd3, 1'b0);
    chk("t2_load", ones, 3); chk("t2_run0", running, 0);
    pulse_start();
    chk("t2_runE0", running, 1); chk("t2_onesE0", ones, 3);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t2_ones", ones, k < 4 ? 3 : k < 8 ? 2 : k < 12 ? 1 : k < 16 ? 0 : 9);
      chk("t2_ten", tens_en, k == 15);
      chk("t2_run", running, 1);
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("t2_pause", running, 0); chk("t2_pones", ones, 9);

    // 3: 2,1,0 with tens_zero -> DONE, no borrow
    do_load(4'd2, 1'b1);
    chk("t3_load", ones, 2);
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t3_ones", ones, k < 4 ? 2 : k < 8 ? 1 : 0);
      chk("t3_ten", tens_en, 0);
      chk("t3_run", running, k < 12);
      chk("t3_done", done, k >= 12);
    end
    start = 1'b1; step(); step(); start = 1'b0;
    chk("t3_stdone", done, 1); chk("t3_strun", running, 0); chk("t3_stones", ones, 0);

    // 4: pause/resume keeps prescaler phase
    do_load(4'd5, 1'b0);
    chk("t4_ldone", done, 0); chk("t4_load", ones, 5);
    pulse_start();
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_pause", running, 0);
    repeat (10) step();
    chk("t4_held", ones, 5); chk("t4_hrun", running, 0);
    pulse_start();
    chk("t4_R0run", running, 1); chk("t4_R0", ones, 5);
    step(); chk("t4_R1", ones, 5);
    step(); chk("t4_R2", ones, 4);

    // 5: saturated load; load ignored while running
    stop = 1'b1; step(); stop = 1'b0;
    do_load(4'd12, 1'b0);
    chk("t5_sat", ones, 9);
    pulse_start();
    step(); step();
    data = 4'd1; loadn = 1'b0; step(); loadn = 1'b1;
    chk("t5_ign", ones, 9); chk("t5_run", running, 1);
    step(); chk("t5_dec", ones, 8);

    // 6: async clr while tens_en is high
    stop = 1'b1; step(); stop = 1'b0;
    do_load(4'd0, 1'b0);
    pulse_start();
    step(); step(); step();
    chk("t6_tenhi", tens_en, 1);
    #3 clr = 1'b1;
    #1;
    chk("t6_ones", ones, 0); chk("t6_run", running, 0);
    chk("t6_ten", tens_en, 0); chk("t6_done", done, 0);
    #2 clr = 1'b0;
    step();
    chk("t6_idle", running, 0);
    // zero-time DONE from IDLE proves the state came back as IDLE
    tens_zero = 1'b1;
    pulse_start();
    chk("t6_zdone", done, 1); chk("t6_zrun", running, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
